// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller for the core's data-memory port.
// Accepts one load or store at a time, drives a single-port word memory
// with arbitrary grant/read latency, and returns aligned, extended load
// data over a valid/ready response channel.
// Optional build macro: LSU_MISALIGN_TRAP_EN (flag misaligned half/word
// accesses as errors instead of silently aligning them down).
module lsu_ctrl #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [2:0]        req_func3,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q;
    logic [1:0]        off_q;
    logic [2:0]        func3_q;
    logic [3:0]        be_q;
    logic [ADDR_W-3:0] waddr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              accept;
    logic              illegal;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       ld_data;

    // Address bits above the memory window are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_W];

    assign accept = (state_q == S_IDLE) && req_valid;

    // Decode legality of the incoming request.
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        illegal = 1'b0;
        if (req_we) begin
            illegal = !(req_func3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            illegal = (req_func3 inside {3'b011, 3'b110, 3'b111});
        end
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_func3[1:0] == 2'b01) && req_addr[0]) begin
            illegal = 1'b1;
        end
        if ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) begin
            illegal = 1'b1;
        end
`endif
    end

    // Byte enables and lane-replicated data for stores; loads write nothing.
    always_comb begin
        st_be    = 4'b0000;
        st_wdata = req_wdata;
        if (req_we) begin
            case (req_func3[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << req_addr[1:0];
                    st_wdata = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    st_be    = 4'b0011 << {req_addr[1], 1'b0};
                    st_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = req_wdata;
                end
            endcase
        end
    end

    // Select the addressed byte/half of the returned word and extend it.
    always_comb begin
        case (off_q)
            2'b00:   lane_b = mem_rdata[7:0];
            2'b01:   lane_b = mem_rdata[15:8];
            2'b10:   lane_b = mem_rdata[23:16];
            default: lane_b = mem_rdata[31:24];
        endcase
        lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (func3_q)
            3'b000:  ld_data = {{24{lane_b[7]}}, lane_b};
            3'b100:  ld_data = {24'h0, lane_b};
            3'b001:  ld_data = {{16{lane_h[15]}}, lane_h};
            3'b101:  ld_data = {16'h0, lane_h};
            default: ld_data = mem_rdata;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid)  state_d = illegal ? S_RESP : S_ISSUE;
            S_ISSUE: if (mem_gnt)    state_d = we_q ? S_RESP : S_WAIT;
            S_WAIT:  if (mem_rvalid) state_d = S_RESP;
            S_RESP:  if (rsp_ready)  state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture, memory command registers and the response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            off_q   <= 2'b00;
            func3_q <= 3'b000;
            be_q    <= 4'b0000;
            waddr_q <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                off_q   <= req_addr[1:0];
                func3_q <= req_func3;
                if (illegal) begin
                    rdata_q <= 32'h0;
                    err_q   <= 1'b1;
                end else begin
                    // Memory command only changes for accesses that will be issued.
                    be_q    <= st_be;
                    waddr_q <= req_addr[ADDR_W-1:2];
                    wdata_q <= st_wdata;
                end
            end
            if ((state_q == S_ISSUE) && mem_gnt && we_q) begin
                rdata_q <= 32'h0;
                err_q   <= 1'b0;
            end
            if ((state_q == S_WAIT) && mem_rvalid) begin
                rdata_q <= ld_data;
                err_q   <= 1'b0;
            end
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_en    = (state_q == S_ISSUE);
    assign mem_we    = (state_q == S_ISSUE) ? be_q : 4'b0000;
    assign mem_addr  = waddr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed scoreboard bench for lsu_ctrl. A driver issues
// requests and plays the memory; a monitor pops expected responses and
// compares whenever the controller presents one.
module tb_lsu_ctrl;

    localparam int ADDR_W = 14;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [2:0]        req_func3;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_func3(req_func3), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   stall_cycles = 0;
    int   vcnt = 0;
    bit   mon_first = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response sink: hold rsp_ready low for stall_cycles of rsp_valid.
    always @(posedge clk) begin
        #1;
        if (rsp_valid) begin
            vcnt++;
            rsp_ready = (vcnt > stall_cycles);
        end else begin
            vcnt = 0;
            rsp_ready = 1'b0;
        end
    end

    // Monitor: compare every presented response against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_without_request: rdata %h err %b", rsp_rdata, rsp_err);
            end else begin
                if (mon_first) begin
                    check({sb[0].name, "_latency"}, cyc - sb[0].acc, sb[0].lat);
                    mon_first = 1'b0;
                end
                check({sb[0].name, "_rdata"}, rsp_rdata, sb[0].rdata);
                check({sb[0].name, "_err"}, rsp_err, sb[0].err);
                check({sb[0].name, "_req_ready"}, req_ready, 0);
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    mon_first = 1'b1;
                end
            end
        end
    end

    task automatic check_reset_values(input string p);
        check({p, "_req_ready"}, req_ready, 1);
        check({p, "_rsp_valid"}, rsp_valid, 0);
        check({p, "_rsp_err"}, rsp_err, 0);
        check({p, "_rsp_rdata"}, rsp_rdata, 0);
        check({p, "_mem_en"}, mem_en, 0);
        check({p, "_mem_we"}, mem_we, 0);
        check({p, "_mem_addr"}, mem_addr, 0);
        check({p, "_mem_wdata"}, mem_wdata, 0);
    endtask

    // One complete transaction: request, memory side, then drain.
    task automatic do_txn(input string name, input logic we, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] wd,
                          input int gw, input int rw, input logic [31:0] md,
                          input logic [31:0] exp_rd, input logic exp_err,
                          input logic [3:0] exp_we, input logic [11:0] exp_maddr,
                          input logic [31:0] exp_wd, input int stall);
        exp_t e;
        int   n;
        bit   saw_en;
        stall_cycles = stall;
        e.name  = name;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = exp_err ? 1 : (we ? 2 + gw : 3 + gw + rw);
        e.acc   = cyc;
        sb.push_back(e);
        check({name, "_accept_ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_func3 = f3;
        req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        saw_en = mem_en;
        if (!exp_err) begin
            for (int i = 0; i < gw; i++) begin
                check({name, "_hold_en"}, mem_en, 1);
                check({name, "_hold_addr"}, mem_addr, exp_maddr);
                check({name, "_hold_we"}, mem_we, exp_we);
                @(posedge clk); #1;
            end
            check({name, "_mem_en"}, mem_en, 1);
            check({name, "_mem_we"}, mem_we, exp_we);
            check({name, "_mem_addr"}, mem_addr, exp_maddr);
            if (we) check({name, "_mem_wdata"}, mem_wdata, exp_wd);
            mem_gnt = 1'b1;
            @(posedge clk); #1;
            mem_gnt = 1'b0;
            if (!we) begin
                for (int i = 0; i < rw; i++) begin
                    check({name, "_wait_no_en"}, mem_en, 0);
                    @(posedge clk); #1;
                end
                mem_rvalid = 1'b1;
                mem_rdata  = md;
                @(posedge clk); #1;
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h0;
            end
        end
        n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < 60) begin
            @(posedge clk); #1;
            if (mem_en) saw_en = 1'b1;
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: response not completed within %0d cycles", name, n);
            sb.delete();
            mon_first = 1'b1;
        end
        if (exp_err) check({name, "_no_mem_en"}, saw_en, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        rsp_ready  = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_func3  = 3'b000;
        req_wdata  = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        //      name        we    addr          f3      wdata         gw rw mdata         exp_rd        err   mem_we   maddr   mem_wdata     stall
        do_txn("sb_1003",   1'b1, 32'h0000_1003, 3'b000, 32'h0000_00A5, 0, 0, 32'h0,        32'h0,        1'b0, 4'b1000, 12'h400, 32'hA5A5_A5A5, 0);
        do_txn("lb_2",      1'b0, 32'h0000_0002, 3'b000, 32'h0,         0, 3, 32'h0080_FF00, 32'hFFFF_FF80, 1'b0, 4'b0000, 12'h000, 32'h0,         0);
        do_txn("lbu_2",     1'b0, 32'h0000_0002, 3'b100, 32'h0,         0, 3, 32'h0080_FF00, 32'h0000_0080, 1'b0, 4'b0000, 12'h000, 32'h0,         0);
        do_txn("lhu_2",     1'b0, 32'h0000_0002, 3'b101, 32'h0,         0, 3, 32'h0080_FF00, 32'h0000_0080, 1'b0, 4'b0000, 12'h000, 32'h0,         0);
        do_txn("lw_gnt4",   1'b0, 32'h0000_0010, 3'b010, 32'h0,         4, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4'b0000, 12'h004, 32'h0,         0);
        do_txn("sh_6",      1'b1, 32'h0000_0006, 3'b001, 32'h0000_1234, 1, 0, 32'h0,        32'h0,        1'b0, 4'b1100, 12'h001, 32'h1234_1234, 0);
        do_txn("sw_8",      1'b1, 32'h0000_0008, 3'b010, 32'hCAFE_F00D, 0, 0, 32'h0,        32'h0,        1'b0, 4'b1111, 12'h002, 32'hCAFE_F00D, 0);
        do_txn("lh_stall",  1'b0, 32'h0000_0000, 3'b001, 32'h0,         0, 1, 32'h0000_8001, 32'hFFFF_8001, 1'b0, 4'b0000, 12'h000, 32'h0,         5);
        do_txn("lh_pos",    1'b0, 32'h0000_0002, 3'b001, 32'h0,         2, 0, 32'h7FFF_0000, 32'h0000_7FFF, 1'b0, 4'b0000, 12'h000, 32'h0,         0);
`ifdef LSU_MISALIGN_TRAP_EN
        do_txn("lw_6",      1'b0, 32'h0000_0006, 3'b010, 32'h0,         0, 0, 32'h0,        32'h0,        1'b1, 4'b0000, 12'h000, 32'h0,         0);
`else
        do_txn("lw_6",      1'b0, 32'h0000_0006, 3'b010, 32'h0,         0, 0, 32'h1122_3344, 32'h1122_3344, 1'b0, 4'b0000, 12'h001, 32'h0,         0);
`endif
        do_txn("ld_f3_011", 1'b0, 32'h0000_0000, 3'b011, 32'h0,         0, 0, 32'h0,        32'h0,        1'b1, 4'b0000, 12'h000, 32'h0,         0);
        do_txn("st_f3_100", 1'b1, 32'h0000_0004, 3'b100, 32'h5555_5555, 0, 0, 32'h0,        32'h0,        1'b1, 4'b0000, 12'h000, 32'h0,         0);

        // Reset while a load waits for read data, then a stray rvalid.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0020;
        req_func3 = 3'b010;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_gnt   = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        check("wait_mem_en_low", mem_en, 0);
        check("wait_rsp_valid_low", rsp_valid, 0);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        for (int i = 0; i < 4; i++) begin
            check("stray_rvalid_rsp_valid", rsp_valid, 0);
            check("stray_rvalid_req_ready", req_ready, 1);
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
